// File: rtl/int_source_timer_pkg.sv
// int_source_timer_pkg: shared state encoding, register map and default addresses for the interrupt timer
package int_source_timer_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_FIRE} state_t;
   localparam logic [3:0] OFF_CTRL = 4'h0;
   localparam logic [3:0] OFF_PRESET = 4'h4;
   localparam logic [3:0] OFF_COUNT = 4'h8;
   localparam int CTRL_EN = 0;
   localparam int CTRL_MODE = 1;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F30;
   localparam logic [31:0] DEF_ACK_ADDR = 32'h0000_7F20;
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/int_source_regs.sv
// int_source_regs: byte-merged CTRL/PRESET registers and combinational read mux of the timer window
//   clk, reset (async, active-low) | addr, wdata, byteen: CPU data bus | count: live COUNT value
//   clr_en: one-shot fire clears EN | en_next: EN value taking effect this edge | mode, preset, rdata
import int_source_timer_pkg::*;
module int_source_regs #(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   input  logic [31:0] count,
   input  logic        clr_en,
   output logic        en_next,
   output logic        mode,
   output logic [31:0] preset,
   output logic [31:0] rdata
);
   logic [31:0] off;
   logic        in_win, wr, ctrl_wr, en;
   assign off = (addr & ~32'h3) - BASE_ADDR;
   assign in_win = off < 32'd16;
   assign wr = in_win && (byteen != 4'b0);
   assign ctrl_wr = wr && off[3:0] == OFF_CTRL && byteen[0];
   // a CPU write of EN overrides the one-shot self-clear on the same edge
   assign en_next = ctrl_wr ? wdata[CTRL_EN] : (clr_en ? 1'b0 : en);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en <= 1'b0;
         mode <= 1'b0;
         preset <= '0;
      end else begin
         en <= en_next;
         if (ctrl_wr) mode <= wdata[CTRL_MODE];
         if (wr && off[3:0] == OFF_PRESET) preset <= merge_bytes(preset, wdata, byteen);
      end
   end
   assign rdata = !in_win ? 32'h0 :
                  off[3:0] == OFF_CTRL ? {30'h0, mode, en} :
                  off[3:0] == OFF_PRESET ? preset :
                  off[3:0] == OFF_COUNT ? count : 32'h0;
endmodule

// File: rtl/int_source_timer.sv
// int_source_timer: programmable down-counter raising a sticky interrupt cleared by an acknowledge write
//   clk, reset (async, active-low) | addr, wdata, byteen, rdata: CPU data bus
//   int_addr, int_byteen: interrupt-acknowledge bus | interrupt: registered level request
import int_source_timer_pkg::*;
module int_source_timer #(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] ACK_ADDR = DEF_ACK_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   input  logic [31:0] int_addr,
   input  logic [3:0]  int_byteen,
   output logic        interrupt
);
   state_t      state, state_nx;
   logic [31:0] count, count_nx, preset;
   logic        pending, en_next, mode, clr_en, ack;
   int_source_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byteen(byteen),
      .count(count), .clr_en(clr_en), .en_next(en_next), .mode(mode),
      .preset(preset), .rdata(rdata)
   );
   assign ack = int_addr == ACK_ADDR && int_byteen != 4'b0;
   assign clr_en = state == S_FIRE && !mode;
   // the FSM reacts to the EN value being written this edge, so a CTRL write starts LOAD immediately
   always_comb begin
      state_nx = state;
      count_nx = count;
      unique case (state)
         S_IDLE:  state_nx = en_next ? S_LOAD : S_IDLE;
         S_LOAD: begin
            count_nx = preset == 32'h0 ? 32'h1 : preset;
            state_nx = S_COUNT;
         end
         S_COUNT: begin
            if (!en_next) state_nx = S_IDLE;
            else if (count <= 32'h1) begin
               count_nx = 32'h0;
               state_nx = S_FIRE;
            end else count_nx = count - 32'h1;
         end
         S_FIRE:  state_nx = mode ? S_LOAD : S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         count <= '0;
         pending <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         pending <= state == S_FIRE || (pending && !ack);
      end
   end
   assign interrupt = pending;
endmodule

// File: tb/tb_int_source_timer.sv
// tb_int_source_timer: directed and randomized checks of the interrupt timer against an arithmetic timing model
module tb_int_source_timer;
   localparam logic [31:0] BASE = 32'h0000_7F30;
   localparam logic [31:0] ACK = 32'h0000_7F20;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0, wdata = '0, int_addr = '0, rdata;
   logic [3:0]  byteen = '0, int_byteen = '0;
   logic        interrupt;
   int n_cmp = 0, n_bad = 0;

   int_source_timer dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byteen(byteen),
      .rdata(rdata), .int_addr(int_addr), .int_byteen(int_byteen), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr = a;
      wdata = d;
      byteen = be;
      tick();
      byteen = 4'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr = a;
      byteen = 4'b0;
      #1;
      v = rdata;
   endtask

   task automatic send_ack(input logic [31:0] a, input logic [3:0] be);
      int_addr = a;
      int_byteen = be;
      tick();
      int_byteen = 4'b0;
   endtask

   // Model: with effective preset E, one period spans E+2 edges after the CTRL write;
   // COUNT after edge m is E-q for phase q=(m-1) < E, else 0; fire lands on edges that are multiples of the period.
   task automatic run(input int n, input bit per, input int edges, input int ack_mode, input string tag);
      int ne, p, q;
      bit exp_pend, ack_now, fire;
      ne = (n == 0) ? 1 : n;
      p = ne + 2;
      exp_pend = 1'b0;
      wr(BASE + 32'h4, 32'(n), 4'hF);
      wr(BASE, per ? 32'h3 : 32'h1, 4'h1);
      addr = BASE + 32'h8;
      int_addr = ACK;
      for (int m = 1; m <= edges; m++) begin
         ack_now = (ack_mode == 1) || (ack_mode == 0 && exp_pend);
         int_byteen = ack_now ? 4'b0001 : 4'b0000;
         tick();
         fire = per ? (m % p == 0) : (m == p);
         exp_pend = fire ? 1'b1 : (ack_now ? 1'b0 : exp_pend);
         q = per ? (m - 1) % p : m - 1;
         chk({tag, "_count"}, rdata, q < ne ? 32'(ne - q) : 32'h0);
         chk({tag, "_irq"}, {31'h0, interrupt}, {31'h0, exp_pend});
      end
      int_byteen = 4'b0;
   endtask

   task automatic stop_timer(input string tag);
      wr(BASE, 32'h0, 4'h1);
      repeat (8) tick();
      send_ack(ACK, 4'b0001);
      chk({tag, "_stop_irq"}, {31'h0, interrupt}, 32'h0);
      repeat (4) tick();
      chk({tag, "_stop_idle"}, {31'h0, interrupt}, 32'h0);
   endtask

   initial begin
      logic [31:0] v, p, w, mask;
      logic [3:0]  b;
      int n;
      #12;
      chk("rst_irq", {31'h0, interrupt}, 32'h0);
      rd(BASE, v);            chk("rst_ctrl", v, 32'h0);
      rd(BASE + 32'h4, v);    chk("rst_preset", v, 32'h0);
      rd(BASE + 32'h8, v);    chk("rst_count", v, 32'h0);
      @(negedge clk) reset = 1'b1;
      tick();

      wr(BASE + 32'h4, 32'hAABBCCDD, 4'hF);
      wr(BASE + 32'h4, 32'h11223344, 4'b0101);
      rd(BASE + 32'h4, v);    chk("merge_fixed", v, 32'hAA22CC44);
      for (int i = 0; i < 4; i++) begin
         p = $urandom;
         w = $urandom;
         b = 4'($urandom_range(0, 15));
         mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
         wr(BASE + 32'h4, p, 4'hF);
         wr(BASE + 32'h4, w, b);
         rd(BASE + 32'h4, v);
         chk("merge_rand", v, (w & mask) | (p & ~mask));
      end
      wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
      rd(BASE + 32'h8, v);    chk("count_ro", v, 32'h0);
      rd(BASE + 32'hC, v);    chk("read_c", v, 32'h0);
      rd(32'h0000_7F00, v);   chk("read_outside_lo", v, 32'h0);
      rd(32'h0000_7F40, v);   chk("read_outside_hi", v, 32'h0);

      wr(BASE + 32'h4, 32'd100, 4'hF);
      wr(BASE, 32'h1, 4'h1);
      repeat (20) tick();
      #2 reset = 1'b0;
      #1 chk("amid_irq", {31'h0, interrupt}, 32'h0);
      rd(BASE + 32'h8, v);    chk("amid_count", v, 32'h0);
      rd(BASE, v);            chk("amid_ctrl", v, 32'h0);
      @(negedge clk) reset = 1'b1;
      repeat (10) tick();
      rd(BASE + 32'h8, v);    chk("amid_idle_count", v, 32'h0);
      chk("amid_idle_irq", {31'h0, interrupt}, 32'h0);

      run(3, 1'b0, 55, 2, "oneshot3");
      rd(BASE, v);            chk("oneshot_ctrl", v, 32'h0);
      send_ack(32'h0000_7F24, 4'b0001);
      chk("ack_wrong_addr", {31'h0, interrupt}, 32'h1);
      send_ack(ACK, 4'b0000);
      chk("ack_no_byteen", {31'h0, interrupt}, 32'h1);
      send_ack(ACK, 4'b0001);
      chk("ack_clear", {31'h0, interrupt}, 32'h0);
      send_ack(ACK, 4'b0001);
      chk("ack_idle", {31'h0, interrupt}, 32'h0);

      run(0, 1'b0, 6, 2, "preset0");
      send_ack(ACK, 4'b1000);
      chk("preset0_ack", {31'h0, interrupt}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n = $urandom_range(0, 9);
         run(n, 1'b0, n + 8, 2, "oneshot_rand");
         send_ack(ACK, 4'b0010);
         chk("oneshot_rand_ack", {31'h0, interrupt}, 32'h0);
      end

      run(4, 1'b1, 30, 0, "periodic4");
      stop_timer("periodic4");
      run(1, 1'b1, 15, 1, "collide1");
      stop_timer("collide1");
      for (int i = 0; i < 2; i++) begin
         n = $urandom_range(1, 6);
         run(n, 1'b1, 4 * (n + 2), 0, "periodic_rand");
         stop_timer("periodic_rand");
      end

      wr(BASE + 32'h4, 32'd10, 4'hF);
      wr(BASE, 32'h1, 4'h1);
      repeat (5) tick();
      rd(BASE + 32'h8, v);    chk("dis_pre_count", v, 32'd6);
      wr(BASE, 32'h0, 4'h1);
      addr = BASE + 32'h8;
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("dis_count", rdata, 32'd6);
         chk("dis_irq", {31'h0, interrupt}, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/int_source_timer.md
Name: int_source_timer

Overview:
- Memory-mapped interrupt source and the device-side responder to the CPU's external-interrupt interface.
- Sits on the CPU data bus (addr/wdata/byteen/rdata) and on the interrupt-acknowledge bus (int_addr/int_byteen).
- Drives the CPU's interrupt input.
- A programmable down-counter raises a sticky interrupt. The interrupt is held until the CPU acknowledges it by writing to the acknowledge address.

Parameters:
- BASE_ADDR, 32'h0000_7F30, base of the 3-word register window (word-aligned).
- ACK_ADDR, 32'h0000_7F20, address whose write (any byteen bit set) clears the pending interrupt.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset), deasserted synchronously by the environment
- addr  in  32  CPU data address (byte address; bits [1:0] ignored)
- wdata  in  32  CPU write data
- byteen  in  4  CPU byte enables; write occurs when nonzero and addr in window
- rdata  out  32  combinational read data for addr; 0 when addr is outside the window
- int_addr  in  32  CPU interrupt-acknowledge address
- int_byteen  in  4  acknowledge byte enables; ack = (int_addr==ACK_ADDR) && (int_byteen!=0)
- interrupt  out  1  level interrupt request to CPU, registered

Behaviour:
- Register map:
  - BASE+0 CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 periodic), other bits read 0.
  - BASE+4 PRESET: 32-bit, read/write.
  - BASE+8 COUNT: read-only; writes are ignored.
  - BASE+C: reads 0.
- Writes merge per byte: only bytes with byteen[i]=1 update.
- Reset (async, reset==0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, interrupt=0.
- FSM states: IDLE, LOAD, COUNT, FIRE.
  - IDLE: stay while EN=0. EN=1 at a clock edge -> LOAD next cycle.
  - LOAD: COUNT <= (PRESET==0 ? 1 : PRESET) -> COUNT.
  - COUNT: if EN=0 -> IDLE (COUNT holds its value). Else if COUNT<=1 -> COUNT <= 0, go to FIRE. Else COUNT <= COUNT-1.
  - FIRE: pending <= 1. If MODE=0: clear EN, -> IDLE. If MODE=1: -> LOAD.
- Latency:
  - Enable written at edge k -> LOAD at k+1 -> first decrement at k+2.
  - For PRESET=N>=1, FIRE is entered N cycles after LOAD.
  - interrupt rises on the edge leaving FIRE, so PRESET=3 written with EN at edge 0 gives interrupt=1 after edge 5.
- interrupt = pending (registered). Pending is sticky until an ack.
- Simultaneous events:
  - ack and FIRE on the same edge: pending stays 1 (fire wins).
  - CPU write to CTRL in the same cycle as a FIRE in one-shot mode: the CPU write wins for EN.
  - A PRESET write during COUNT does not affect the current COUNT; it is used on the next LOAD.
  - A CTRL write of EN=0 during LOAD: LOAD completes, then COUNT sees EN=0 and goes to IDLE.
- Ack outside a pending interrupt: no effect.
- rdata is combinational from addr and current register values; a read and write on the same cycle returns the pre-write value.
- COUNT decrement never wraps: the 0 boundary is handled by the COUNT<=1 rule.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, COUNT, FIRE);
  - register offsets (CTRL=0, PRESET=4, COUNT=8);
  - CTRL bit indices (EN=0, MODE=1);
  - default BASE_ADDR/ACK_ADDR constants, shared with the CPU's bridge and the system bench.
- One sub-module is natural: int_source_regs, the byte-enable-merged register file plus read mux. The FSM/counter and the ack logic stay in the top module.

Test Plan:
- Reset mid-count: PRESET=100, EN=1, pull reset low at cycle 20 -> interrupt=0, COUNT reads 0, CTRL reads 0 immediately (async); after release, state stays IDLE.
- One-shot: write PRESET=3, then CTRL=32'h1 -> interrupt=1 exactly 5 edges after the CTRL write; CTRL reads 0; interrupt stays 1 for 50 cycles; ack write (int_addr=32'h7F20, int_byteen=4'b0001) -> interrupt=0 next edge.
- Periodic: PRESET=4, CTRL=32'h3, ack each time interrupt rises -> interrupt rises every 6 cycles (LOAD+4 COUNT+FIRE) for 5 periods; COUNT reads 4,3,2,1,0 sequence.
- Byte merge: PRESET=32'hAABBCCDD, write wdata=32'h11223344 with byteen=4'b0101 -> PRESET reads 32'hAA22CC44; a write to BASE+8 leaves COUNT unchanged.
- Collision and edge cases:
  - Periodic PRESET=1 with ack asserted on the FIRE edge -> interrupt stays 1.
  - PRESET=0 behaves as 1.
  - Ack to 32'h7F24 -> ignored.
  - Read of 32'h7F00 returns 0.
- Disable mid-count: PRESET=10, EN=1, clear EN at count 6 -> no interrupt for 30 cycles; COUNT holds 6.
